// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage and the core's IF/ID pipe.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DROP  = 2'd1,
    S_FULL  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } if_id_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry instr+pc holding register used while the core stalls the fetch stage.
module fetch_skid_buffer
  import instr_fetch_unit_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   load_i,
  input  logic   clear_i,
  input  if_id_t data_i,
  output logic   valid_o,
  output if_id_t data_o
);

  logic   valid_q;
  if_id_t data_q;

  // Clear wins so a redirect always empties the entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, fetches from variable-latency imem, feeds the core.
// Handshake: imem_req/imem_addr hold steady until imem_ack; one request outstanding.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC         = 32'h0,
  parameter logic [31:0] PC_STEP          = 32'd1,
  parameter logic [31:0] NOP_INSTR        = instr_fetch_unit_pkg::NOP_INSTR,
  parameter logic [31:0] FETCH_COUNT_INIT = 32'h0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         pc_write,
  input  logic         branch_taken,
  input  logic [31:0]  branch_target,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  instr_out,
  output logic [31:0]  pc_out,
  output logic         instr_valid,
  output logic [31:0]  fetch_count,
  output fetch_state_e fetch_state
);

  fetch_state_e state_q;
  logic [31:0]  fetch_pc_q;
  logic [31:0]  drop_addr_q;
  logic [31:0]  instr_q;
  logic [31:0]  pc_q;
  logic [31:0]  count_q;
  logic         valid_q;

  logic   buf_load;
  logic   buf_clear;
  logic   buf_valid;
  if_id_t buf_in;
  if_id_t buf_data;

  // Request is masked while reset is held so the memory sees no request.
  assign imem_req  = reset && (state_q != S_FULL);
  assign imem_addr = (state_q == S_DROP) ? drop_addr_q : fetch_pc_q;

  assign buf_in    = '{instr: imem_rdata, pc: fetch_pc_q};
  assign buf_load  = !branch_taken && (state_q == S_FETCH) && imem_ack && !pc_write;
  assign buf_clear = branch_taken || ((state_q == S_FULL) && pc_write);

  fetch_skid_buffer u_skid (
    .clk_i   (clock),
    .rst_ni  (reset),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .data_i  (buf_in),
    .valid_o (buf_valid),
    .data_o  (buf_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
      instr_q     <= NOP_INSTR;
      pc_q        <= RESET_PC;
      valid_q     <= 1'b0;
      count_q     <= FETCH_COUNT_INIT;
    end else if (branch_taken) begin
      fetch_pc_q <= branch_target;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
      // An un-acked request cannot be withdrawn, so its reply must be dropped.
      if (imem_req && !imem_ack) begin
        if (state_q == S_FETCH) drop_addr_q <= fetch_pc_q;
        state_q <= S_DROP;
      end else begin
        state_q <= S_FETCH;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ack) begin
            fetch_pc_q <= fetch_pc_q + PC_STEP;
            if (pc_write) begin
              instr_q <= imem_rdata;
              pc_q    <= fetch_pc_q;
              valid_q <= 1'b1;
              count_q <= count_q + 32'd1;
            end else begin
              state_q <= S_FULL;
            end
          end else if (pc_write) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
          end
        end
        S_FULL: begin
          if (pc_write && buf_valid) begin
            instr_q <= buf_data.instr;
            pc_q    <= buf_data.pc;
            valid_q <= 1'b1;
            count_q <= count_q + 32'd1;
            state_q <= S_FETCH;
          end
        end
        S_DROP: begin
          if (imem_ack) state_q <= S_FETCH;
          if (pc_write) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign instr_out   = instr_q;
  assign pc_out      = pc_q;
  assign instr_valid = valid_q;
  assign fetch_count = count_q;
  assign fetch_state = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic against a reference model.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam logic [31:0] NOP = 32'hD503201F;

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  // primary DUT (RESET_PC = 0)
  logic        pc_write, branch_taken, imem_ack;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr_out, pc_out, fetch_count;
  logic [1:0]  state1;

  // wrap DUT (RESET_PC and count preset at all-ones, zero-wait memory)
  logic        pc_write2 = 1'b1, branch_taken2 = 1'b0, imem_ack2 = 1'b1;
  logic [31:0] branch_target2 = 32'h0, imem_rdata2;
  logic        imem_req2, instr_valid2;
  logic [31:0] imem_addr2, instr_out2, pc_out2, fetch_count2;
  logic [1:0]  state2;

  instr_fetch_unit dut (
    .clock(clock), .reset(reset), .pc_write(pc_write), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_out(instr_out), .pc_out(pc_out),
    .instr_valid(instr_valid), .fetch_count(fetch_count), .fetch_state(state1)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFFFFFF), .FETCH_COUNT_INIT(32'hFFFFFFFF)) dut2 (
    .clock(clock), .reset(reset), .pc_write(pc_write2), .branch_taken(branch_taken2),
    .branch_target(branch_target2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .instr_out(instr_out2), .pc_out(pc_out2),
    .instr_valid(instr_valid2), .fetch_count(fetch_count2), .fetch_state(state2)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // reference model: what the core must see, in transaction terms
  logic [31:0] m_instr, m_pc, m_cnt, m_fpc, m_daddr;
  logic        m_valid, m_drop;
  logic [63:0] skid_q[$];

  // memory model
  int mem_wait, mem_lat, lat_mode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pin(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                     input logic [31:0] lit);
    chk({name, "_dut"}, dut_v, lit);
    chk({name, "_model"}, mdl_v, lit);
  endtask

  function automatic logic m_req();
    return reset && (skid_q.size() == 0);
  endfunction

  function automatic logic [31:0] m_addr();
    return m_drop ? m_daddr : m_fpc;
  endfunction

  task automatic model_reset();
    m_instr = NOP; m_pc = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    m_fpc = 32'h0; m_daddr = 32'h0; m_drop = 1'b0;
    skid_q.delete();
  endtask

  task automatic model_edge();
    logic req, got;
    if (!reset) begin
      model_reset();
      return;
    end
    req = m_req();
    got = req && imem_ack;
    if (branch_taken) begin
      if (req && !got && !m_drop) begin m_drop = 1'b1; m_daddr = m_fpc; end
      else if (got) m_drop = 1'b0;
      m_fpc = branch_target;
      skid_q.delete();
      m_instr = NOP; m_valid = 1'b0;
    end else if (m_drop) begin
      if (got) m_drop = 1'b0;
      if (pc_write) begin m_instr = NOP; m_valid = 1'b0; end
    end else if (skid_q.size() != 0) begin
      if (pc_write) begin
        {m_instr, m_pc} = skid_q.pop_front();
        m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
      end
    end else if (got) begin
      if (pc_write) begin
        m_instr = imem_rdata; m_pc = m_fpc; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
      end else begin
        skid_q.push_back({imem_rdata, m_fpc});
      end
      m_fpc = m_fpc + 32'd1;
    end else if (pc_write) begin
      m_instr = NOP; m_valid = 1'b0;
    end
    if (got) begin
      mem_wait = 0;
      mem_lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
    end else if (req) begin
      mem_wait++;
    end
  endtask

  task automatic compare();
    chk("imem_req", 32'(imem_req), 32'(m_req()));
    if (m_req()) chk("imem_addr", imem_addr, m_addr());
    chk("instr_out", instr_out, m_instr);
    chk("pc_out", pc_out, m_pc);
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  task automatic cyc();
    @(negedge clock);
    compare();
    imem_ack    = imem_req && (mem_wait >= mem_lat);
    imem_rdata  = imem_ack ? imem_addr + 32'd100 : $urandom;
    imem_rdata2 = imem_addr2 + 32'd100;
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    model_reset();
    mem_wait = 0;
    mem_lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
    repeat (2) cyc();
  endtask

  initial begin
    reset = 1'b0; pc_write = 1'b1; branch_taken = 1'b0; branch_target = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0; imem_rdata2 = 32'h0;
    lat_mode = 0;
    #2;
    apply_reset();
    pin("rst_instr", instr_out, m_instr, NOP);
    pin("rst_pc", pc_out, m_pc, 32'h0);
    pin("rst_valid", 32'(instr_valid), 32'(m_valid), 32'h0);
    pin("rst_count", fetch_count, m_cnt, 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_count2", fetch_count2, 32'hFFFFFFFF);
    chk("rst_pc2", pc_out2, 32'hFFFFFFFF);
    reset = 1'b1;
    #1;
    chk("rel_req", 32'(imem_req), 32'h1);
    chk("rel_addr", imem_addr, 32'h0);

    // zero-wait memory
    cyc();
    pin("zw0_instr", instr_out, m_instr, 32'd100);
    pin("zw0_pc", pc_out, m_pc, 32'd0);
    chk("zw0_addr", imem_addr, 32'd1);
    chk("wrap_instr2", instr_out2, 32'h63);
    chk("wrap_pc2", pc_out2, 32'hFFFFFFFF);
    chk("wrap_addr2", imem_addr2, 32'h0);
    chk("wrap_count2", fetch_count2, 32'h0);
    cyc();
    pin("zw1_instr", instr_out, m_instr, 32'd101);
    chk("zw1_addr", imem_addr, 32'd2);
    cyc();
    pin("zw2_instr", instr_out, m_instr, 32'd102);
    pin("zw2_pc", pc_out, m_pc, 32'd2);
    chk("zw2_addr", imem_addr, 32'd3);
    pin("zw2_count", fetch_count, m_cnt, 32'd3);
    repeat (2) cyc();
    pin("zw4_instr", instr_out, m_instr, 32'd104);

    // stall while delivering pc 4
    pc_write = 1'b0;
    cyc();
    pin("st_instr", instr_out, m_instr, 32'd104);
    pin("st_pc", pc_out, m_pc, 32'd4);
    chk("st_req", 32'(imem_req), 32'h0);
    repeat (2) cyc();
    pin("st2_instr", instr_out, m_instr, 32'd104);
    chk("st2_req", 32'(imem_req), 32'h0);
    pc_write = 1'b1;
    cyc();
    pin("unst_instr", instr_out, m_instr, 32'd105);
    pin("unst_pc", pc_out, m_pc, 32'd5);
    chk("unst_addr", imem_addr, 32'd6);

    // branch while request for pc 7 is outstanding
    cyc();
    mem_lat = 3; mem_wait = 0;
    branch_taken = 1'b1; branch_target = 32'd40;
    cyc();
    branch_taken = 1'b0;
    pin("br_instr", instr_out, m_instr, NOP);
    pin("br_valid", 32'(instr_valid), 32'(m_valid), 32'h0);
    chk("br_hold_addr", imem_addr, 32'd7);
    for (int i = 0; i < 10; i++) begin
      if (imem_req && imem_addr == 32'd40) break;
      cyc();
    end
    chk("br_target_addr", imem_addr, 32'd40);
    cyc();
    pin("br_tgt_instr", instr_out, m_instr, 32'd140);
    pin("br_tgt_pc", pc_out, m_pc, 32'd40);

    // branch together with stall while buffer is full
    pc_write = 1'b0;
    cyc();
    chk("bs_full_req", 32'(imem_req), 32'h0);
    branch_taken = 1'b1; branch_target = 32'd20;
    cyc();
    branch_taken = 1'b0;
    pin("bs_instr", instr_out, m_instr, NOP);
    pin("bs_count", fetch_count, m_cnt, 32'd8);
    chk("bs_addr", imem_addr, 32'd20);
    pc_write = 1'b1;
    cyc();
    pin("bs_tgt_instr", instr_out, m_instr, 32'd120);

    // two-cycle memory latency from reset
    lat_mode = 2;
    apply_reset();
    reset = 1'b1;
    cyc();
    pin("lat1_instr", instr_out, m_instr, NOP);
    chk("lat1_addr", imem_addr, 32'd0);
    cyc();
    pin("lat2_valid", 32'(instr_valid), 32'(m_valid), 32'h0);
    chk("lat2_addr", imem_addr, 32'd0);
    cyc();
    pin("lat3_instr", instr_out, m_instr, 32'd100);
    pin("lat3_pc", pc_out, m_pc, 32'd0);

    // randomized traffic with occasional mid-cycle reset
    lat_mode = -1;
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) begin
        apply_reset();
        reset = 1'b1;
      end
      pc_write      = ($urandom_range(0, 3) != 0);
      branch_taken  = ($urandom_range(0, 9) == 0);
      branch_target = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF8 + 32'($urandom_range(0, 7)))
                                                  : 32'($urandom_range(0, 255));
      cyc();
    end
    branch_taken = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
